// File: rtl/master_reset_decoder_pkg.sv
// Shared definitions for the master reset decoder: one-hot state encoding,
// default thresholds and a small saturating-increment helper.
package master_reset_decoder_pkg;

  localparam int IDLE_BIT = 0;
  localparam int MEAS_BIT = 1;
  localparam int SRST_BIT = 2;
  localparam int LRST_BIT = 3;

  typedef enum logic [3:0] {
    ST_IDLE = 4'b0001 << IDLE_BIT,
    ST_MEAS = 4'b0001 << MEAS_BIT,
    ST_SRST = 4'b0001 << SRST_BIT,
    ST_LRST = 4'b0001 << LRST_BIT
  } decState_e;

  localparam int DEF_SYNC_STAGES = 2;
  localparam int DEF_CNT_W       = 8;
  localparam int DEF_MIN_LEN     = 2;
  localparam int DEF_SHORT_MAX   = 4;
  localparam int DEF_STUCK_LEN   = 255;
  localparam int DEF_OUT_LEN     = 1;

  function automatic logic [7:0] satInc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/master_reset_decoder_sync_bit.sv
// Multi-flop synchroniser for a single asynchronous input bit, cleared to 0 on reset.
module sync_bit
  import master_reset_decoder_pkg::*;
#(
  parameter int STAGES = DEF_SYNC_STAGES
) (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic q_o
);

  logic [STAGES-1:0] chain_q;

  always_ff @(posedge clk) begin
    if (rst) chain_q <= '0;
    else     chain_q <= {chain_q[STAGES-2:0], d_i};
  end

  assign q_o = chain_q[STAGES-1];

endmodule

// File: rtl/master_reset_decoder.sv
// Decodes pulse-width-encoded reset commands from the master into short/long
// reset pulses, with glitch counting and stuck-high detection.
module master_reset_decoder
  import master_reset_decoder_pkg::*;
#(
  parameter int SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int CNT_W       = DEF_CNT_W,
  parameter int MIN_LEN     = DEF_MIN_LEN,
  parameter int SHORT_MAX   = DEF_SHORT_MAX,
  parameter int STUCK_LEN   = DEF_STUCK_LEN,
  parameter int OUT_LEN     = DEF_OUT_LEN
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rst_from_master,
  output logic             short_reset,
  output logic             long_reset,
  output logic             stuck_err,
  output logic [CNT_W-1:0] last_len,
  output logic [7:0]       glitch_cnt
);

  localparam int OW = $clog2(OUT_LEN + 1);
  localparam int FW = $clog2(SYNC_STAGES + 1);
  localparam logic [CNT_W-1:0] LEN_MIN   = CNT_W'(MIN_LEN);
  localparam logic [CNT_W-1:0] LEN_SHORT = CNT_W'(SHORT_MAX);
  localparam logic [CNT_W-1:0] LEN_STUCK = CNT_W'(STUCK_LEN);
  localparam logic [OW-1:0]    OUT_W     = OW'(OUT_LEN);
  localparam logic [FW-1:0]    FILL_FULL = FW'(SYNC_STAGES);

  logic             lineSync;
  logic             lineDly_q;
  logic [FW-1:0]    fill_q;
  logic             armed_q;
  logic             rise;
  decState_e        state_q, state_d;
  logic [CNT_W-1:0] len_q, len_d;
  logic [OW-1:0]    outCnt_q, outCnt_d;
  logic             short_q, short_d;
  logic             long_q, long_d;
  logic             stuck_q, stuck_d;
  logic [CNT_W-1:0] lastLen_q, lastLen_d;
  logic [7:0]       glitch_q, glitch_d;

  sync_bit #(.STAGES(SYNC_STAGES)) u_sync (
    .clk (clk),
    .rst (rst),
    .d_i (rst_from_master),
    .q_o (lineSync)
  );

  // A line still high across a reset must not look like a fresh edge once the
  // cleared chain refills, so edges count only after a genuine low is seen.
  assign rise = lineSync & ~lineDly_q & armed_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      lineDly_q <= 1'b0;
      fill_q    <= '0;
      armed_q   <= 1'b0;
      state_q   <= ST_IDLE;
      len_q     <= '0;
      outCnt_q  <= '0;
      short_q   <= 1'b0;
      long_q    <= 1'b0;
      stuck_q   <= 1'b0;
      lastLen_q <= '0;
      glitch_q  <= '0;
    end else begin
      lineDly_q <= lineSync;
      if (fill_q != FILL_FULL) fill_q <= fill_q + 1'b1;
      if (fill_q == FILL_FULL && !lineSync) armed_q <= 1'b1;
      state_q   <= state_d;
      len_q     <= len_d;
      outCnt_q  <= outCnt_d;
      short_q   <= short_d;
      long_q    <= long_d;
      stuck_q   <= stuck_d;
      lastLen_q <= lastLen_d;
      glitch_q  <= glitch_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    len_d     = len_q;
    outCnt_d  = outCnt_q;
    short_d   = 1'b0;
    long_d    = 1'b0;
    stuck_d   = stuck_q;
    lastLen_d = lastLen_q;
    glitch_d  = glitch_q;
    unique case (state_q)
      ST_IDLE: begin
        if (rise) begin
          state_d = ST_MEAS;
          len_d   = CNT_W'(1);
        end
      end
      ST_MEAS: begin
        if (lineSync) begin
          if (len_q != LEN_STUCK) len_d = len_q + 1'b1;
          if (len_d == LEN_STUCK) stuck_d = 1'b1;
        end else begin
          lastLen_d = len_q;
          if (stuck_q) begin
            state_d = ST_IDLE;
            stuck_d = 1'b0;
          end else if (len_q < LEN_MIN) begin
            state_d  = ST_IDLE;
            glitch_d = satInc8(glitch_q);
          end else if (len_q <= LEN_SHORT) begin
            state_d  = ST_SRST;
            short_d  = 1'b1;
            outCnt_d = OW'(1);
          end else begin
            state_d  = ST_LRST;
            long_d   = 1'b1;
            outCnt_d = OW'(1);
          end
        end
      end
      ST_SRST: begin
        if (outCnt_q >= OUT_W) begin
          state_d = ST_IDLE;
        end else begin
          outCnt_d = outCnt_q + 1'b1;
          short_d  = 1'b1;
        end
      end
      ST_LRST: begin
        if (outCnt_q >= OUT_W) begin
          state_d = ST_IDLE;
        end else begin
          outCnt_d = outCnt_q + 1'b1;
          long_d   = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign short_reset = short_q;
  assign long_reset  = long_q;
  assign stuck_err   = stuck_q;
  assign last_len    = lastLen_q;
  assign glitch_cnt  = glitch_q;

endmodule

// File: tb/tb_master_reset_decoder.sv
// Directed bench for master_reset_decoder: two instances (OUT_LEN 1 and 4) share
// one command line; output pulses are checked against a queue of expected events.
module tb_master_reset_decoder;

  logic       clk = 1'b0;
  logic       rst;
  logic       lineIn;
  logic       short0, long0, stuck0;
  logic       short1, long1, stuck1;
  logic [7:0] last0, glitch0, last1, glitch1;

  int cyc = 0;
  int totalCount = 0;
  int badCount = 0;

  typedef struct {
    logic [1:0] kind;
    int         width;
    int         start;
  } expT;

  expT expQ0[$];
  expT expQ1[$];

  master_reset_decoder dut0 (
    .clk             (clk),
    .rst             (rst),
    .rst_from_master (lineIn),
    .short_reset     (short0),
    .long_reset      (long0),
    .stuck_err       (stuck0),
    .last_len        (last0),
    .glitch_cnt      (glitch0)
  );

  master_reset_decoder #(.OUT_LEN(4)) dut1 (
    .clk             (clk),
    .rst             (rst),
    .rst_from_master (lineIn),
    .short_reset     (short1),
    .long_reset      (long1),
    .stuck_err       (stuck1),
    .last_len        (last1),
    .glitch_cnt      (glitch1)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    totalCount++;
    assert (observed === expected) else begin
      badCount++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  task automatic checkPulse(input int idx, input logic [1:0] kind, input int width, input int start);
    expT e;
    int  qSize;
    qSize = (idx == 0) ? expQ0.size() : expQ1.size();
    if (qSize == 0) begin
      checkOutput($sformatf("unexpected_pulse%0d", idx), 32'(kind), 0);
    end else begin
      if (idx == 0) e = expQ0.pop_front();
      else          e = expQ1.pop_front();
      checkOutput($sformatf("pulse_kind%0d", idx), 32'(kind), 32'(e.kind));
      checkOutput($sformatf("pulse_width%0d", idx), width, e.width);
      checkOutput($sformatf("pulse_start%0d", idx), start, e.start);
    end
  endtask

  // Output pulse monitor for the OUT_LEN=1 instance.
  initial begin
    int w = 0;
    int st = 0;
    logic [1:0] k = 2'b00;
    forever begin
      @(negedge clk);
      checkOutput("exclusive0", 32'(short0 & long0), 0);
      if (short0 | long0) begin
        if (w == 0) begin
          st = cyc;
          k  = {long0, short0};
        end
        w++;
      end else if (w > 0) begin
        checkPulse(0, k, w, st);
        w = 0;
      end
    end
  end

  // Output pulse monitor for the OUT_LEN=4 instance.
  initial begin
    int w = 0;
    int st = 0;
    logic [1:0] k = 2'b00;
    forever begin
      @(negedge clk);
      checkOutput("exclusive1", 32'(short1 & long1), 0);
      if (short1 | long1) begin
        if (w == 0) begin
          st = cyc;
          k  = {long1, short1};
        end
        w++;
      end else if (w > 0) begin
        checkPulse(1, k, w, st);
        w = 0;
      end
    end
  end

  // Drive an n-cycle high pulse; kind 01 = short, 10 = long, 00 = nothing expected.
  task automatic applyStimulus(input int n, input logic [1:0] kind);
    expT e;
    int  d;
    lineIn = 1'b1;
    repeat (n) @(posedge clk);
    #1;
    lineIn = 1'b0;
    d = cyc;
    if (kind != 2'b00) begin
      e.kind  = kind;
      e.start = d + 3;
      e.width = 1;
      expQ0.push_back(e);
      e.width = 4;
      expQ1.push_back(e);
    end
    repeat (12) @(posedge clk);
    #1;
  endtask

  initial begin
    rst    = 1'b1;
    lineIn = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_short0", 32'(short0), 0);
    checkOutput("rst_long0", 32'(long0), 0);
    checkOutput("rst_stuck0", 32'(stuck0), 0);
    checkOutput("rst_last0", 32'(last0), 0);
    checkOutput("rst_glitch0", 32'(glitch0), 0);
    checkOutput("rst_short1", 32'(short1), 0);
    rst = 1'b0;
    repeat (10) @(posedge clk);
    #1;

    applyStimulus(1, 2'b00);
    checkOutput("glitch_cnt_a", 32'(glitch0), 1);
    checkOutput("glitch_last_a", 32'(last0), 1);
    checkOutput("glitch_cnt_a1", 32'(glitch1), 1);

    applyStimulus(3, 2'b01);
    checkOutput("short3_last0", 32'(last0), 3);
    checkOutput("short3_last1", 32'(last1), 3);

    applyStimulus(10, 2'b10);
    checkOutput("long10_last0", 32'(last0), 10);

    applyStimulus(4, 2'b01);
    checkOutput("short4_last1", 32'(last1), 4);

    applyStimulus(5, 2'b10);
    checkOutput("long5_last1", 32'(last1), 5);

    applyStimulus(1, 2'b00);
    checkOutput("glitch_cnt_b", 32'(glitch0), 2);
    checkOutput("glitch_last_b", 32'(last0), 1);

    // Stuck-high line: 300 cycles high.
    lineIn = 1'b1;
    repeat (256) @(posedge clk);
    #1;
    checkOutput("stuck_before", 32'(stuck0), 0);
    @(posedge clk);
    #1;
    checkOutput("stuck_at255", 32'(stuck0), 1);
    checkOutput("stuck_at255_1", 32'(stuck1), 1);
    repeat (43) @(posedge clk);
    #1;
    checkOutput("stuck_held", 32'(stuck0), 1);
    lineIn = 1'b0;
    repeat (12) @(posedge clk);
    #1;
    checkOutput("stuck_cleared", 32'(stuck0), 0);
    checkOutput("stuck_last0", 32'(last0), 255);
    checkOutput("stuck_glitch0", 32'(glitch0), 2);

    // Reset in the middle of an 8+ cycle pulse; line stays high afterwards.
    lineIn = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    checkOutput("midrst_last0", 32'(last0), 0);
    checkOutput("midrst_glitch0", 32'(glitch0), 0);
    repeat (20) @(posedge clk);
    #1;
    lineIn = 1'b0;
    repeat (12) @(posedge clk);
    #1;
    checkOutput("held_not_decoded_last0", 32'(last0), 0);
    checkOutput("held_not_decoded_glitch0", 32'(glitch0), 0);
    checkOutput("held_not_decoded_stuck0", 32'(stuck0), 0);

    applyStimulus(3, 2'b01);
    checkOutput("after_rst_last0", 32'(last0), 3);
    checkOutput("after_rst_last1", 32'(last1), 3);

    checkOutput("pending_q0", expQ0.size(), 0);
    checkOutput("pending_q1", expQ1.size(), 0);

    $display("test done: total=%0d bad=%0d", totalCount, badCount);
    $finish;
  end

endmodule
